// File: rtl/cmp_unit_seq.sv
// Multi-cycle branch-condition comparator: one SLICE-bit adder pass per cycle, LSB first,
// with valid/ready handshakes on both sides and registered Z/N/V/C flags.
module cmp_unit_seq #(
  parameter int N     = 16,
  parameter int SLICE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         cond,
  output logic         zero,
  output logic         neg,
  output logic         ofl,
  output logic         cout
);

  localparam int STEPS = N / SLICE;
  localparam int KW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [N-1:0]  a_q, b_q;
  logic [3:0]    op_q;
  logic          carry_q, zero_acc_q;
  logic [KW-1:0] k_q;
  logic          cond_q, zero_q, neg_q, ofl_q, cout_q;

  logic          load, step, finish;
  logic [N-1:0]  b_sel;
  logic          cin_sel;
  logic [SLICE:0]   slice_full;
  logic [SLICE-1:0] slice_sum;
  logic          k_last;
  logic          zero_f, neg_f, ofl_f, cout_f, cond_f;

  // Operand select: ops 0-3 compare A against zero, op 7 adds, everything else subtracts.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    b_sel   = ~b;
    cin_sel = 1'b1;
    if (op <= 4'd3) begin
      b_sel   = '0;
      cin_sel = 1'b0;
    end else if (op == 4'd7) begin
      b_sel   = b;
      cin_sel = 1'b0;
    end
  end

  always_comb begin
    slice_full = (SLICE+1)'(a_q[k_q*SLICE +: SLICE]) + (SLICE+1)'(b_q[k_q*SLICE +: SLICE])
               + (SLICE+1)'(carry_q);
    slice_sum  = slice_full[SLICE-1:0];
    k_last     = (k_q == KW'(STEPS - 1));
    zero_f     = zero_acc_q & ~|slice_sum;
    neg_f      = slice_sum[SLICE-1];
    cout_f     = slice_full[SLICE];
    ofl_f      = (a_q[N-1] & b_q[N-1] & ~neg_f) | (~a_q[N-1] & ~b_q[N-1] & neg_f);
    unique case (op_q)
      4'd0:    cond_f = ~zero_f;
      4'd1:    cond_f = zero_f;
      4'd2:    cond_f = neg_f ^ ofl_f;
      4'd3:    cond_f = ~(neg_f ^ ofl_f);
      4'd4:    cond_f = zero_f;
      4'd5:    cond_f = neg_f ^ ofl_f;
      4'd6:    cond_f = (neg_f ^ ofl_f) | zero_f;
      4'd7:    cond_f = cout_f;
      4'd8:    cond_f = ~cout_f;
      4'd9:    cond_f = ~cout_f | zero_f;
      4'd10:   cond_f = ~zero_f;
      4'd11:   cond_f = ~(neg_f ^ ofl_f) & ~zero_f;
      default: cond_f = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: if (in_valid) begin
        state_d = RUN;
        load    = 1'b1;
      end
      RUN: begin
        step = 1'b1;
        if (k_last) begin
          state_d = DONE;
          finish  = 1'b1;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q    <= 1'b0;
      zero_acc_q <= 1'b0;
      k_q        <= '0;
      cond_q     <= 1'b0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      ofl_q      <= 1'b0;
      cout_q     <= 1'b0;
    end else begin
      if (load) begin
        carry_q    <= cin_sel;
        zero_acc_q <= 1'b1;
        k_q        <= '0;
      end else if (step) begin
        carry_q    <= cout_f;
        zero_acc_q <= zero_f;
        k_q        <= k_q + KW'(1);
      end
      if (finish) begin
        cond_q <= cond_f;
        zero_q <= zero_f;
        neg_q  <= neg_f;
        ofl_q  <= ofl_f;
        cout_q <= cout_f;
      end
    end
  end

  // NOTE: operand latches carry no reset; they are always written on acceptance before being read.
  always_ff @(posedge clk) begin
    if (load) begin
      a_q  <= a;
      b_q  <= b_sel;
      op_q <= op;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign cond      = cond_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ofl       = ofl_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_cmp_unit_seq.sv
// Directed bench for cmp_unit_seq: hand-computed flag vectors packed as {cond,zero,neg,ofl,cout}.
module tb_cmp_unit_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b;
  logic [3:0]  op;
  logic        cond, zero, neg, ofl, cout;

  int checks = 0;
  int errors = 0;

  cmp_unit_seq #(.N(16), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .cond(cond), .zero(zero), .neg(neg), .ofl(ofl), .cout(cout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] flags();
    return {cond, zero, neg, ofl, cout};
  endfunction

  // Issues one request from IDLE and checks the 4-edge latency; leaves the unit in DONE.
  task automatic do_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                       input logic [3:0] opv, input logic [4:0] exp);
    check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    a = av; b = bv; op = opv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = ~av; b = ~bv; op = ~opv;
    check({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
    tick(); tick(); tick();
    check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_flags"}, 32'(flags()), 32'(exp));
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_rel_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_rel_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = '0;
    #12;
    check("reset_flags", 32'(flags()), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // FFFE - 0003 = FFFB: negative, no overflow, carry out set
    do_op("c1_slt", 16'hFFFE, 16'h0003, 4'd5, 5'b10101);
    release_out("c1");
    // 8000 - 0001 = 7FFF: signed overflow
    do_op("c2_slt_ovf", 16'h8000, 16'h0001, 4'd5, 5'b10011);
    release_out("c2");
    // 0001 - FFFF = 0002 with borrow
    do_op("c3_ultu", 16'h0001, 16'hFFFF, 4'd8, 5'b10000);
    release_out("c3a");
    do_op("c3_slt", 16'h0001, 16'hFFFF, 4'd5, 5'b00000);
    release_out("c3b");
    do_op("c3_uleu", 16'h0001, 16'hFFFF, 4'd9, 5'b10000);
    release_out("c3c");
    // FFFF + 0001 wraps to zero with carry out
    do_op("c4_add", 16'hFFFF, 16'h0001, 4'd7, 5'b11001);
    release_out("c4a");
    // reserved op: flags still computed (5-3=2, carry), cond forced low
    do_op("c4_rsvd", 16'h0005, 16'h0003, 4'd13, 5'b00001);
    release_out("c4b");

    // Backpressure with a competing request that must be ignored
    do_op("c5_bp", 16'hFFFE, 16'h0003, 4'd5, 5'b10101);
    for (int i = 0; i < 5; i++) begin
      a = 16'h0001; b = 16'h0002; op = 4'd1; in_valid = 1'b1;
      tick();
      check($sformatf("c5_hold_valid_%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("c5_hold_flags_%0d", i), 32'(flags()), 32'b10101);
      check($sformatf("c5_hold_ready_%0d", i), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    release_out("c5");
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("c5_no_second_%0d", i), 32'(out_valid), 32'd0);
    end
    check("c5_idle_flags_kept", 32'(flags()), 32'b10101);

    // Reset while RUN is at k=2
    a = 16'h8000; b = 16'h0001; op = 4'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("c6_async_flags", 32'(flags()), 32'd0);
    check("c6_async_out_valid", 32'(out_valid), 32'd0);
    check("c6_async_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("c6_no_valid_%0d", i), 32'(out_valid), 32'd0);
    end
    do_op("c6_eq", 16'h1234, 16'h1234, 4'd4, 5'b11001);
    release_out("c6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmp_unit_seq.md
Name: cmp_unit_seq

Overview:
- Parametrised, multi-cycle successor to the single-cycle branch-condition comparator.
- Evaluates an operand-select/compare op on N-bit operands using an SLICE-bit adder that is iterated LSB-first, one slice per cycle.
- Adds unsigned and extra signed conditions, and exposes Z/N/V/C flags.
- Sits between the decode operand latches and branch resolution, with valid/ready handshakes on both sides.

Parameters:
- N, 16, operand width; must be a multiple of SLICE.
- SLICE, 4, adder slice width per cycle.
- STEPS = N/SLICE, derived localparam, not overridable.

Ports:
- clk, input, 1, single clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, request valid.
- in_ready, output, 1, unit can accept a request (high only in IDLE).
- a, input, N, operand A.
- b, input, N, operand B.
- op, input, 4, condition select.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts result.
- cond, output, 1, condition result.
- zero, output, 1, Z flag.
- neg, output, 1, N flag.
- ofl, output, 1, V flag.
- cout, output, 1, C flag.

Behaviour:
- Reset (async assert, sync release) forces state IDLE. out_valid, cond, zero, neg, ofl and cout all read 0. in_ready=1. Internal slice counter, carry and accumulators are cleared.
- Operand select, latched at acceptance:
  - op 0-3: B_in=0, cin=0.
  - op 7: B_in=b, cin=0 (add).
  - All other ops: B_in=~b, cin=1 (A-B).
- Condition table:
  - 0: ~Z
  - 1: Z
  - 2: N^V
  - 3: ~(N^V)
  - 4: Z
  - 5: N^V (signed A<B)
  - 6: (N^V)|Z
  - 7: C
  - 8: ~C (unsigned A<B)
  - 9: ~C|Z (unsigned A<=B)
  - 10: ~Z
  - 11: ~(N^V)&~Z (signed A>B)
  - 12-15: reserved, cond=0, flags still computed.
- State machine:
  - IDLE:
    - in_ready=1.
    - On in_valid at a rising edge: latch a, B_in, cin and op. Set carry=cin, zero_acc=1, k=0. Go to RUN.
  - RUN (STEPS cycles):
    - in_ready=0.
    - Each edge adds slices a[k*SLICE+:SLICE] + B_in[k*SLICE+:SLICE] + carry.
    - Stores the carry out, and clears zero_acc if the slice sum is nonzero. k increments.
    - On the edge processing k=STEPS-1, registers the outputs and goes to DONE:
      - zero = zero_acc after the final slice.
      - neg = sum[N-1].
      - ofl = (a[N-1]&B_in[N-1]&~sum[N-1]) | (~a[N-1]&~B_in[N-1]&sum[N-1]).
      - cout = final carry.
      - cond = per table.
  - DONE:
    - out_valid=1. cond and flags are held stable while out_ready=0.
    - When out_ready=1 at an edge, go to IDLE; out_valid drops next cycle.
- Latency: out_valid rises STEPS edges after the acceptance edge (4 for defaults).
- Throughput: at most one request per STEPS+2 cycles. No overlap between requests.
- in_valid outside IDLE is ignored and not queued. Operand changes after acceptance have no effect.
- Outputs change only on entry to DONE or on reset; they keep their last values in IDLE/RUN, with out_valid=0.
- Reset mid-RUN or mid-DONE aborts the operation: no out_valid pulse, IDLE next.
- STEPS=1 is legal: the unit is in RUN for one cycle.

Test Plan:
1. op=5, a=0xFFFE, b=0x0003 -> after 4 cycles out_valid=1, cond=1, neg=1, ofl=0, zero=0.
2. op=5, a=0x8000, b=0x0001 -> sum 0x7FFF, ofl=1, neg=0, cout=1, cond=1.
3. a=0x0001, b=0xFFFF:
   - op=8 -> cond=1 (cout=0).
   - Repeat with op=5 -> cond=0.
   - Repeat with op=9 -> cond=1.
4. op=7, a=0xFFFF, b=0x0001 -> cout=1, zero=1, cond=1.
   - Also op=13, any operands -> cond=0.
5. Backpressure: run case 1 and hold out_ready=0 for 5 cycles while pulsing in_valid with a new request:
   - out_valid and cond stay 1, in_ready stays 0, and the second request is ignored.
   - Releasing out_ready gives in_ready=1 next cycle.
6. Reset mid-operation: assert rst_n=0 during RUN at k=2:
   - Outputs go to 0 immediately (async), in_ready=1, and no out_valid follows.
   - A subsequent op=4, a=b=0x1234 returns zero=1, cond=1.
